// File: rtl/alu_exec_unit.sv
`default_nettype none

// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Single-cycle MIPS execute-stage slice. Holds the PC register
//            and its PC+4 incrementer, decodes ALUOp/funct into a 4-bit ALU
//            operation, and performs the 32-bit ALU operation with a Zero
//            flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_operation,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    // ALUOp encodings from the main control unit
    localparam logic [1:0] C_ALUOP_MEM    = 2'b00;
    localparam logic [1:0] C_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] C_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] C_ALUOP_IMM    = 2'b11;

    // R-type funct field values
    localparam logic [5:0] C_FUNCT_ADD = 6'h20;
    localparam logic [5:0] C_FUNCT_SUB = 6'h22;
    localparam logic [5:0] C_FUNCT_AND = 6'h24;
    localparam logic [5:0] C_FUNCT_OR  = 6'h25;
    localparam logic [5:0] C_FUNCT_NOR = 6'h27;
    localparam logic [5:0] C_FUNCT_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] C_OP_AND     = 4'b0000;
    localparam logic [3:0] C_OP_OR      = 4'b0001;
    localparam logic [3:0] C_OP_ADD     = 4'b0010;
    localparam logic [3:0] C_OP_SUB     = 4'b0110;
    localparam logic [3:0] C_OP_SLT     = 4'b0111;
    localparam logic [3:0] C_OP_NOR     = 4'b1100;
    localparam logic [3:0] C_OP_INVALID = 4'b1111;

    localparam logic [WIDTH-1:0] C_PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic [3:0]       op_w;
    logic [WIDTH-1:0] result_w;
    logic             slt_w;

    // Next PC is chosen outside this block; the register loads it every cycle
    always_comb begin
        pc_d = next_pc;
    end

    // PC register; asynchronous reset overrides any coincident clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // Sequential-fetch address; wraps modulo 2^WIDTH
    always_comb begin
        pc_plus4 = pc_q + C_PC_STEP;
    end

    // ALU control: map ALUOp (and funct for R-type) onto an ALU operation
    always_comb begin
        op_w = C_OP_INVALID;
        case (alu_op)
            C_ALUOP_MEM:    op_w = C_OP_ADD;
            C_ALUOP_BRANCH: op_w = C_OP_SUB;
            C_ALUOP_RTYPE: begin
                case (funct)
                    C_FUNCT_ADD: op_w = C_OP_ADD;
                    C_FUNCT_SUB: op_w = C_OP_SUB;
                    C_FUNCT_AND: op_w = C_OP_AND;
                    C_FUNCT_OR:  op_w = C_OP_OR;
                    C_FUNCT_SLT: op_w = C_OP_SLT;
                    C_FUNCT_NOR: op_w = C_OP_NOR;
                    default:     op_w = C_OP_INVALID;
                endcase
            end
            C_ALUOP_IMM:    op_w = C_OP_ADD;
            default:        op_w = C_OP_INVALID;
        endcase
    end

    assign alu_operation = op_w;

    // Signed compare for slt; operands are treated as two's complement
    always_comb begin
        slt_w = ($signed(a) < $signed(b));
    end

    // ALU datapath; unknown operation codes yield zero so Zero stays defined
    always_comb begin
        result_w = '0;
        case (op_w)
            C_OP_AND: result_w = a & b;
            C_OP_OR:  result_w = a | b;
            C_OP_ADD: result_w = a + b;
            C_OP_SUB: result_w = a - b;
            C_OP_SLT: result_w = {{(WIDTH-1){1'b0}}, slt_w};
            C_OP_NOR: result_w = ~(a | b);
            default:  result_w = '0;
        endcase
    end

    assign alu_result = result_w;

    // Zero flag follows the result for every operation, invalid ones included
    always_comb begin
        zero = (result_w == '0);
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none

// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed self-checking bench for alu_exec_unit. Each step pushes
//            its expected outputs to a scoreboard queue; the check step pops
//            every pending entry and compares it with the live DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 32;

    localparam int SEL_PC    = 0;
    localparam int SEL_PC4   = 1;
    localparam int SEL_OP    = 2;
    localparam int SEL_RES   = 3;
    localparam int SEL_ZERO  = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_result;
    logic             zero;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    alu_exec_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .next_pc       (next_pc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .alu_op        (alu_op),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .zero          (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PC:   return pc;
            SEL_PC4:  return pc_plus4;
            SEL_OP:   return {28'd0, alu_operation};
            SEL_RES:  return alu_result;
            SEL_ZERO: return {31'd0, zero};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT now
    task automatic check_all();
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic alu_step(input string tag, input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic [3:0] exp_op, input logic [31:0] exp_res,
                            input logic exp_zero);
        alu_op = op;
        funct  = fn;
        a      = va;
        b      = vb;
        expect_val({tag, ".op"},   SEL_OP,   {28'd0, exp_op});
        expect_val({tag, ".res"},  SEL_RES,  exp_res);
        expect_val({tag, ".zero"}, SEL_ZERO, {31'd0, exp_zero});
        #1;
        check_all();
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        next_pc = 32'h0000_0040;
        alu_op  = 2'b00;
        funct   = 6'h00;
        a       = '0;
        b       = '0;

        // Asynchronous reset, no clock edge yet
        #1 reset = 1'b1;
        expect_val("reset.pc",   SEL_PC,  32'h0000_0000);
        expect_val("reset.pc4",  SEL_PC4, 32'h0000_0004);
        #1;
        check_all();

        // Reset holds across a clock edge
        @(posedge clk);
        expect_val("reset_hold.pc", SEL_PC, 32'h0000_0000);
        #1;
        check_all();

        // Release and load
        @(negedge clk);
        reset   = 1'b0;
        next_pc = 32'h0000_001C;
        @(posedge clk);
        expect_val("load.pc",  SEL_PC,  32'h0000_001C);
        expect_val("load.pc4", SEL_PC4, 32'h0000_0020);
        #1;
        check_all();

        // Next load, then mid-cycle reset clears it immediately
        @(negedge clk);
        next_pc = 32'h0000_0080;
        @(posedge clk);
        expect_val("load2.pc", SEL_PC, 32'h0000_0080);
        #1;
        check_all();
        #1 reset = 1'b1;
        expect_val("midreset.pc",  SEL_PC,  32'h0000_0000);
        expect_val("midreset.pc4", SEL_PC4, 32'h0000_0004);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // PC wrap
        next_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        expect_val("wrap.pc",  SEL_PC,  32'hFFFF_FFFC);
        expect_val("wrap.pc4", SEL_PC4, 32'h0000_0000);
        #1;
        check_all();

        // R-type sweep with a = 12, b = 10
        alu_step("r_add", 2'b10, 6'h20, 32'h0000_000C, 32'h0000_000A, 4'b0010, 32'h0000_0016, 1'b0);
        alu_step("r_sub", 2'b10, 6'h22, 32'h0000_000C, 32'h0000_000A, 4'b0110, 32'h0000_0002, 1'b0);
        alu_step("r_and", 2'b10, 6'h24, 32'h0000_000C, 32'h0000_000A, 4'b0000, 32'h0000_0008, 1'b0);
        alu_step("r_or",  2'b10, 6'h25, 32'h0000_000C, 32'h0000_000A, 4'b0001, 32'h0000_000E, 1'b0);
        alu_step("r_nor", 2'b10, 6'h27, 32'h0000_000C, 32'h0000_000A, 4'b1100, 32'hFFFF_FFF1, 1'b0);

        // Branch compare
        alu_step("beq_eq", 2'b01, 6'h00, 32'd9, 32'd9, 4'b0110, 32'h0000_0000, 1'b1);
        alu_step("beq_ne", 2'b01, 6'h3F, 32'd9, 32'd3, 4'b0110, 32'h0000_0006, 1'b0);
        alu_step("sub_wrap", 2'b01, 6'h00, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0);

        // Signed set-less-than
        alu_step("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0);
        alu_step("slt_swp", 2'b10, 6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, 32'h0000_0000, 1'b1);
        alu_step("slt_big", 2'b10, 6'h2A, 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 32'h0000_0000, 1'b1);

        // Memory address, add wrap, immediate add, invalid funct
        alu_step("mem_add",  2'b00, 6'h22, 32'h0000_0100, 32'hFFFF_FFFC, 4'b0010, 32'h0000_00FC, 1'b0);
        alu_step("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000, 1'b1);
        alu_step("imm_add",  2'b11, 6'h24, 32'h0000_0005, 32'h0000_0007, 4'b0010, 32'h0000_000C, 1'b0);
        alu_step("invalid",  2'b10, 6'h00, 32'h0000_000C, 32'h0000_000A, 4'b1111, 32'h0000_0000, 1'b1);

        // ALU keeps following inputs while reset is held
        reset = 1'b1;
        alu_step("rst_alu", 2'b10, 6'h25, 32'hF000_0000, 32'h0000_000F, 4'b0001, 32'hF000_000F, 1'b0);
        expect_val("rst_alu.pc", SEL_PC, 32'h0000_0000);
        #1;
        check_all();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
